// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-requester sequencer in front of a 32-bit ALU
// One operation in flight: IDLE accepts, EXEC runs the ALU, DONE holds the result until consumed.

module alu_core #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  output logic [W-1:0] res,
  output logic         zf,
  output logic         legal
);
  always_comb begin
    res   = '0;
    legal = 1'b1;
    unique case (sel)
      4'd0:    res = a & b;
      4'd1:    res = a | b;
      4'd2:    res = a + b;
      4'd6:    res = a - b;
      4'd7:    res = {{(W-1){1'b0}}, (a < b)};
      4'd12:   res = ~(a | b);
      default: legal = 1'b0;
    endcase
    zf = (res == '0);
  end
endmodule

module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_op1_0,
  input  logic [W-1:0] req_op1_1,
  input  logic [W-1:0] req_op2_0,
  input  logic [W-1:0] req_op2_1,
  input  logic [3:0]   req_sel_0,
  input  logic [3:0]   req_sel_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_zf,
  output logic         out_id,
  output logic         out_err,
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic [W-1:0] op1_q, op1_d;
  logic [W-1:0] op2_q, op2_d;
  logic [3:0]   sel_q, sel_d;
  logic         id_q, id_d;
  logic [W-1:0] res_q, res_d;
  logic         zf_q, zf_d;
  logic         oid_q, oid_d;
  logic         err_q, err_d;

  logic         gnt_id;
  logic         accept;
  logic [W-1:0] alu_res;
  logic         alu_zf;
  logic         alu_legal;

  alu_core #(.W(W)) u_alu (
    .a     (op1_q),
    .b     (op2_q),
    .sel   (sel_q),
    .res   (alu_res),
    .zf    (alu_zf),
    .legal (alu_legal)
  );

  // A tie goes to whoever was not served last; a lone requester always wins.
  assign gnt_id    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign accept    = (state_q == S_IDLE) && (req_valid != 2'b00) && !reset;
  assign req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_res   = res_q;
  assign out_zf    = zf_q;
  assign out_id    = oid_q;
  assign out_err   = err_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    id_d    = id_q;
    res_d   = res_q;
    zf_d    = zf_q;
    oid_d   = oid_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op1_d   = gnt_id ? req_op1_1 : req_op1_0;
          op2_d   = gnt_id ? req_op2_1 : req_op2_0;
          sel_d   = gnt_id ? req_sel_1 : req_sel_0;
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_legal ? alu_res : '0;
        zf_d    = alu_legal ? alu_zf : 1'b1;
        err_d   = ~alu_legal;
        oid_d   = id_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      oid_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      oid_q   <= oid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a phase-level reference model

module tb_alu_arbiter;
  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
  logic [3:0]  req_sel_0, req_sel_1;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic        out_zf, out_id, out_err, busy;

  alu_arbiter #(.W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1_0 (req_op1_0),
    .req_op1_1 (req_op1_1),
    .req_op2_0 (req_op2_0),
    .req_op2_1 (req_op2_1),
    .req_sel_0 (req_sel_0),
    .req_sel_1 (req_sel_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zf    (out_zf),
    .out_id    (out_id),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        id;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Most recently consumed result, for directed checks against fixed values.
  logic [31:0] got_res;
  logic        got_zf, got_id, got_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] s, input logic id);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (s)
      4'd0:    e.res = a & b;
      4'd1:    e.res = a | b;
      4'd2:    e.res = a + b;
      4'd6:    e.res = a - b;
      4'd7:    e.res = (a < b) ? 32'd1 : 32'd0;
      4'd12:   e.res = ~(a | b);
      default: begin e.res = 32'd0; e.err = 1'b1; end
    endcase
    e.zf = (e.res == 32'd0);
    return e;
  endfunction

  // Reference model: which phase the one-at-a-time sequencer is in, and who was served last.
  typedef enum {P_IDLE, P_EXEC, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_last  = 1;
  bit     m_was_reset = 1'b0;

  always @(negedge clk) begin
    int          gid;
    logic [1:0]  exp_rdy;
    if (reset) begin
      chk("ready_in_reset", req_ready, 2'b00);
      m_phase = P_IDLE;
      m_last = 1;
      expq.delete();
      m_was_reset = 1'b1;
    end else begin
      if (m_was_reset) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_flags", {out_zf, out_id, out_err}, 3'b000);
        m_was_reset = 1'b0;
      end
      gid = -1;
      if (m_phase == P_IDLE) begin
        if (req_valid == 2'b11)    gid = (m_last == 0) ? 1 : 0;
        else if (req_valid[0])     gid = 0;
        else if (req_valid[1])     gid = 1;
      end
      exp_rdy = 2'b00;
      if (gid >= 0) exp_rdy[gid] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_phase != P_IDLE);
      chk("out_valid", out_valid, m_phase == P_DONE);
      case (m_phase)
        P_IDLE: if (gid >= 0) begin
          if (gid == 0) expq.push_back(ref_op(req_op1_0, req_op2_0, req_sel_0, 1'b0));
          else          expq.push_back(ref_op(req_op1_1, req_op2_1, req_sel_1, 1'b1));
          m_last  = gid;
          m_phase = P_EXEC;
        end
        P_EXEC: m_phase = P_DONE;
        P_DONE: if (out_ready) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Monitor: every cycle a result is presented it must match the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = expq[0];
        chk("out_res", out_res, e.res);
        chk("out_zf", out_zf, e.zf);
        chk("out_id", out_id, e.id);
        chk("out_err", out_err, e.err);
        if (out_ready) begin
          void'(expq.pop_front());
          got_res = out_res;
          got_zf  = out_zf;
          got_id  = out_id;
          got_err = out_err;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    if (id == 0) begin req_op1_0 = a; req_op2_0 = b; req_sel_0 = s; end
    else         begin req_op1_1 = a; req_op2_1 = b; req_sel_1 = s; end
  endtask

  // Present one request, drop it right after it is taken, then let it drain.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bit got;
    set_req(id, a, b, s);
    req_valid[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    cyc(4);
  endtask

  // Watch for the next grants under a tie; returns ids in order.
  task automatic collect_grants(input int n, output int ids[$]);
    ids = {};
    for (int i = 0; i < 60 && ids.size() < n; i++) begin
      @(negedge clk);
      if (req_ready[0]) ids.push_back(0);
      if (req_ready[1]) ids.push_back(1);
    end
  endtask

  logic [3:0] legal_sels [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

  initial begin
    int ids[$];
    reset = 1'b1;
    req_valid = 2'b00;
    out_ready = 1'b1;
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    cyc(3);
    reset = 1'b0;
    cyc(1);

    issue(0, 32'd5, 32'd3, 4'd2);
    chk("single_res", got_res, 32'd8);
    chk("single_flags", {got_zf, got_id, got_err}, 3'b000);

    issue(1, 32'd7, 32'd7, 4'd6);
    chk("sub_res", got_res, 32'd0);
    chk("sub_zf_id", {got_zf, got_id}, 2'b11);
    issue(1, 32'hFFFF_FFFF, 32'd1, 4'd7);
    chk("slt_res", got_res, 32'd0);
    chk("slt_zf", got_zf, 1'b1);

    set_req(0, 32'd10, 32'd4, 4'd6);
    set_req(1, 32'd1, 32'd2, 4'd1);
    req_valid = 2'b11;
    collect_grants(4, ids);
    req_valid = 2'b00;
    chk("fair_count", ids.size(), 4);
    if (ids.size() == 4) chk("fair_order", {ids[0][1:0], ids[1][1:0], ids[2][1:0], ids[3][1:0]}, 8'b00_01_00_01);
    cyc(4);

    out_ready = 1'b0;
    set_req(0, 32'h1234_5678, 32'h1111_1111, 4'd2);
    req_valid = 2'b01;
    collect_grants(1, ids);
    req_valid = 2'b11;
    cyc(12);
    chk("bp_held", out_valid, 1'b1);
    out_ready = 1'b1;
    cyc(6);
    req_valid = 2'b00;
    cyc(4);

    issue(0, 32'hF0, 32'h0F, 4'd3);
    chk("illegal_res", got_res, 32'd0);
    chk("illegal_zf_err", {got_zf, got_err}, 2'b11);
    issue(0, 32'hF0, 32'h0F, 4'd0);
    chk("legal_after_res", got_res, 32'd0);
    chk("legal_after_zf_err", {got_zf, got_err}, 2'b10);

    // Reset while the op is executing, then while its result is waiting.
    out_ready = 1'b0;
    req_valid = 2'b10;
    collect_grants(1, ids);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(4);
    req_valid = 2'b10;
    collect_grants(1, ids);
    @(posedge clk); #1;
    req_valid = 2'b00;
    cyc(2);
    chk("pre_reset_done", out_valid, 1'b1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    req_valid = 2'b11;
    collect_grants(1, ids);
    chk("tie_after_reset", (ids.size() == 1) ? ids[0] : -1, 0);
    req_valid = 2'b00;
    cyc(4);

    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        logic [31:0] a, b;
        logic [3:0]  s;
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_sels[$urandom_range(0, 5)];
        set_req(r, a, b, s);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    reset = 1'b0;
    req_valid = 2'b00;
    out_ready = 1'b1;
    cyc(6);
    chk("queue_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
